// File: rtl/atm_session_arbiter_if.sv
// Terminal-side and engine-side signals of the ATM session arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding logic's view.
interface atm_session_arbiter_if #(
  parameter int N_TERM = 4,
  parameter int DW     = 12
);
  logic [N_TERM-1:0]    req;
  logic [N_TERM*DW-1:0] term_acct;
  logic [N_TERM*DW-1:0] term_pin;
  logic [N_TERM*DW-1:0] term_dst;
  logic [N_TERM*DW-1:0] term_amt;
  logic [N_TERM*3-1:0]  term_op;
  logic [N_TERM-1:0]    gnt;
  logic [N_TERM-1:0]    term_done;
  logic [N_TERM-1:0]    term_err;
  logic                 busy;
  logic [DW-1:0]        eng_acct;
  logic [DW-1:0]        eng_pin;
  logic [DW-1:0]        eng_dst;
  logic [DW-1:0]        eng_deposit;
  logic [DW-1:0]        eng_withdraw;
  logic [DW-1:0]        eng_transfer;
  logic [2:0]           eng_op;
  logic                 eng_start;
  logic                 eng_done;
  logic                 eng_err;

  modport slave (
    input  req, term_acct, term_pin, term_dst, term_amt, term_op, eng_done, eng_err,
    output gnt, term_done, term_err, busy, eng_acct, eng_pin, eng_dst,
           eng_deposit, eng_withdraw, eng_transfer, eng_op, eng_start
  );

  modport master (
    output req, term_acct, term_pin, term_dst, term_amt, term_op, eng_done, eng_err,
    input  gnt, term_done, term_err, busy, eng_acct, eng_pin, eng_dst,
           eng_deposit, eng_withdraw, eng_transfer, eng_op, eng_start
  );
endinterface

// File: rtl/atm_session_arbiter.sv
// Round-robin arbiter sharing one ATM transaction engine among N_TERM terminals:
// grant, latch request fields, pulse engine start, wait for done/timeout, pulse per-terminal done.
module atm_session_arbiter #(
  parameter int N_TERM  = 4,
  parameter int DW      = 12,
  parameter int TIMEOUT = 64
) (
  input logic                  clk,
  input logic                  rst,
  atm_session_arbiter_if.slave bus
);
  localparam int PW = $clog2(N_TERM);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_START,
    S_WAIT,
    S_RELEASE
  } state_t;

  state_t            state;
  logic [PW-1:0]     rr;
  logic [PW-1:0]     cur;
  logic [TW-1:0]     timer;
  logic              err;

  logic [N_TERM-1:0] req_rot;
  logic [PW-1:0]     pick;
  logic [N_TERM-1:0] pick_oh;
  logic              found;
  int unsigned       sum;

  logic [DW-1:0]     acct_sel;
  logic [DW-1:0]     pin_sel;
  logic [DW-1:0]     dst_sel;
  logic [DW-1:0]     amt_sel;
  logic [2:0]        op_sel;

  // Rotate requests so bit 0 is the terminal at rr; the first set bit is the winner.
  always_comb begin
    req_rot = N_TERM'({bus.req, bus.req} >> rr);
    found   = 1'b0;
    pick    = '0;
    sum     = 0;
    for (int unsigned k = 0; k < N_TERM; k++) begin
      if (!found && req_rot[k]) begin
        found = 1'b1;
        sum   = 32'(rr) + k;
        if (sum >= 32'(N_TERM)) sum = sum - 32'(N_TERM);
        pick  = PW'(sum);
      end
    end
    pick_oh = N_TERM'(1) << pick;
  end

  always_comb begin
    acct_sel = '0;
    pin_sel  = '0;
    dst_sel  = '0;
    amt_sel  = '0;
    op_sel   = '0;
    for (int unsigned k = 0; k < N_TERM; k++) begin
      if (cur == PW'(k)) begin
        acct_sel = bus.term_acct[k*DW +: DW];
        pin_sel  = bus.term_pin[k*DW +: DW];
        dst_sel  = bus.term_dst[k*DW +: DW];
        amt_sel  = bus.term_amt[k*DW +: DW];
        op_sel   = bus.term_op[k*3 +: 3];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= S_IDLE;
      rr               <= '0;
      cur              <= '0;
      timer            <= '0;
      err              <= 1'b0;
      bus.gnt          <= '0;
      bus.term_done    <= '0;
      bus.term_err     <= '0;
      bus.busy         <= 1'b0;
      bus.eng_acct     <= '0;
      bus.eng_pin      <= '0;
      bus.eng_dst      <= '0;
      bus.eng_deposit  <= '0;
      bus.eng_withdraw <= '0;
      bus.eng_transfer <= '0;
      bus.eng_op       <= '0;
      bus.eng_start    <= 1'b0;
    end else begin
      bus.term_done <= '0;
      bus.term_err  <= '0;
      bus.eng_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|bus.req) begin
            cur      <= pick;
            bus.gnt  <= pick_oh;
            bus.busy <= 1'b1;
            state    <= S_GRANT;
          end
        end
        S_GRANT: begin
          bus.eng_acct     <= acct_sel;
          bus.eng_pin      <= pin_sel;
          bus.eng_dst      <= dst_sel;
          bus.eng_op       <= op_sel;
          bus.eng_deposit  <= (op_sel == 3'd0) ? amt_sel : '0;
          bus.eng_withdraw <= (op_sel == 3'd1) ? amt_sel : '0;
          bus.eng_transfer <= (op_sel == 3'd2) ? amt_sel : '0;
          state            <= S_START;
        end
        S_START: begin
          bus.eng_start <= 1'b1;
          timer         <= '0;
          state         <= S_WAIT;
        end
        S_WAIT: begin
          // Done is tested first so it wins over a coincident timeout.
          if (bus.eng_done) begin
            err   <= bus.eng_err;
            state <= S_RELEASE;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            err   <= 1'b1;
            state <= S_RELEASE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_RELEASE: begin
          bus.term_done    <= bus.gnt;
          bus.term_err     <= err ? bus.gnt : '0;
          bus.gnt          <= '0;
          bus.busy         <= 1'b0;
          bus.eng_acct     <= '0;
          bus.eng_pin      <= '0;
          bus.eng_dst      <= '0;
          bus.eng_deposit  <= '0;
          bus.eng_withdraw <= '0;
          bus.eng_transfer <= '0;
          bus.eng_op       <= '0;
          rr               <= (cur == PW'(N_TERM - 1)) ? '0 : cur + 1'b1;
          state            <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_atm_session_arbiter.sv
// Bench for atm_session_arbiter: session-level reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized traffic phase.
module tb_atm_session_arbiter;
  localparam int N  = 4;
  localparam int DW = 12;
  localparam int T  = 16;

  logic clk;
  logic rst;

  atm_session_arbiter_if #(.N_TERM(N), .DW(DW)) bus ();

  atm_session_arbiter #(.N_TERM(N), .DW(DW), .TIMEOUT(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (session level) ----------------
  logic            s_rst, s_edone, s_eerr;
  logic [N-1:0]    s_req;
  logic [N*DW-1:0] s_acct, s_pin, s_dst, s_amt;
  logic [N*3-1:0]  s_op;

  bit m_active = 0, m_pend = 0, m_err = 0;
  int m_cur = 0, m_rr = 0, m_age = 0;

  logic [N-1:0]  e_gnt = '0, e_done = '0, e_terr = '0;
  logic          e_busy = 0, e_start = 0;
  logic [DW-1:0] e_acct = '0, e_pin = '0, e_dst = '0, e_dep = '0, e_wd = '0, e_tr = '0;
  logic [2:0]    e_op = '0;

  task automatic clear_fields();
    e_acct = '0; e_pin = '0; e_dst = '0; e_dep = '0; e_wd = '0; e_tr = '0; e_op = '0;
  endtask

  task automatic model_step();
    logic [DW-1:0] amt;
    e_done = '0; e_terr = '0; e_start = 0;
    if (!s_rst) begin
      m_active = 0; m_pend = 0; m_rr = 0;
      e_gnt = '0; e_busy = 0;
      clear_fields();
      return;
    end
    if (!m_active) begin
      if (s_req != '0) begin
        for (int k = 0; k < N; k++) begin
          int t;
          t = (m_rr + k) % N;
          if (s_req[t]) begin
            m_cur = t;
            break;
          end
        end
        m_active = 1; m_age = 0; m_pend = 0;
        e_gnt = N'(1) << m_cur;
        e_busy = 1;
      end
    end else begin
      m_age++;
      if (m_age == 1) begin
        e_acct = DW'(s_acct >> (m_cur * DW));
        e_pin  = DW'(s_pin >> (m_cur * DW));
        e_dst  = DW'(s_dst >> (m_cur * DW));
        amt    = DW'(s_amt >> (m_cur * DW));
        e_op   = 3'(s_op >> (m_cur * 3));
        e_dep  = (e_op == 3'd0) ? amt : '0;
        e_wd   = (e_op == 3'd1) ? amt : '0;
        e_tr   = (e_op == 3'd2) ? amt : '0;
      end else if (m_age == 2) begin
        e_start = 1;
      end else if (m_pend) begin
        e_done = N'(1) << m_cur;
        e_terr = m_err ? e_done : '0;
        e_gnt  = '0;
        e_busy = 0;
        clear_fields();
        m_rr = (m_cur + 1) % N;
        m_active = 0;
        m_pend = 0;
      end else begin
        // age 3 is the first engine-wait cycle, so (age-3) is cycles already waited
        if (s_edone) begin
          m_err = s_eerr; m_pend = 1;
        end else if (m_age - 3 == T - 1) begin
          m_err = 1; m_pend = 1;
        end
      end
    end
  endtask

  int          done_count = 0;
  int          grant_log[$];
  logic [N-1:0] prev_gnt = '0;

  always begin
    @(posedge clk);
    s_rst = rst; s_req = bus.req; s_acct = bus.term_acct; s_pin = bus.term_pin;
    s_dst = bus.term_dst; s_amt = bus.term_amt; s_op = bus.term_op;
    s_edone = bus.eng_done; s_eerr = bus.eng_err;
    #1;
    model_step();
    chk("gnt",          32'(bus.gnt),          32'(e_gnt));
    chk("term_done",    32'(bus.term_done),    32'(e_done));
    chk("term_err",     32'(bus.term_err),     32'(e_terr));
    chk("busy",         32'(bus.busy),         32'(e_busy));
    chk("eng_start",    32'(bus.eng_start),    32'(e_start));
    chk("eng_acct",     32'(bus.eng_acct),     32'(e_acct));
    chk("eng_pin",      32'(bus.eng_pin),      32'(e_pin));
    chk("eng_dst",      32'(bus.eng_dst),      32'(e_dst));
    chk("eng_deposit",  32'(bus.eng_deposit),  32'(e_dep));
    chk("eng_withdraw", 32'(bus.eng_withdraw), 32'(e_wd));
    chk("eng_transfer", 32'(bus.eng_transfer), 32'(e_tr));
    chk("eng_op",       32'(bus.eng_op),       32'(e_op));
    if (prev_gnt == '0 && bus.gnt != '0) grant_log.push_back($clog2(bus.gnt));
    done_count += $countones(bus.term_done);
    prev_gnt = bus.gnt;
  end

  // ---------------- stimulus helpers ----------------
  logic [DW-1:0] f_acct[N], f_pin[N], f_dst[N], f_amt[N];
  logic [2:0]    f_op[N];

  task automatic pack_fields();
    logic [N*DW-1:0] a, p, d, m;
    logic [N*3-1:0]  o;
    a = '0; p = '0; d = '0; m = '0; o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      a = {a[(N-1)*DW-1:0], f_acct[i]};
      p = {p[(N-1)*DW-1:0], f_pin[i]};
      d = {d[(N-1)*DW-1:0], f_dst[i]};
      m = {m[(N-1)*DW-1:0], f_amt[i]};
      o = {o[(N-1)*3-1:0], f_op[i]};
    end
    bus.term_acct = a; bus.term_pin = p; bus.term_dst = d; bus.term_amt = m; bus.term_op = o;
  endtask

  task automatic rand_term(input int i);
    f_acct[i] = DW'($urandom); f_pin[i] = DW'($urandom);
    f_dst[i]  = DW'($urandom); f_amt[i] = DW'($urandom);
    f_op[i]   = 3'($urandom_range(0, 7));
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic probe(input int sel);
    case (sel)
      0:       return bus.eng_start;
      1:       return |bus.term_done;
      default: return |bus.gnt;
    endcase
  endfunction

  // Returns cycles waited until the selected output is seen high, or -1 on expiry.
  task automatic wait_out(input int sel, input int limit, output int cyc);
    cyc = -1;
    for (int n = 1; n <= limit; n++) begin
      tick();
      if (probe(sel)) begin
        cyc = n;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int cyc, d0, cnt;
    rst = 1'b0; bus.req = '0; bus.eng_done = 1'b0; bus.eng_err = 1'b0;
    for (int i = 0; i < N; i++) begin
      f_acct[i] = '0; f_pin[i] = '0; f_dst[i] = '0; f_amt[i] = '0; f_op[i] = '0;
    end
    pack_fields();

    // Reset with all terminals requesting
    bus.req = 4'b1111;
    repeat (2) tick();
    chk("rst_gnt",       32'(bus.gnt),       32'h0);
    chk("rst_busy",      32'(bus.busy),      32'h0);
    chk("rst_term_done", 32'(bus.term_done), 32'h0);
    chk("rst_eng_start", 32'(bus.eng_start), 32'h0);
    rst = 1'b1; bus.req = '0;
    tick();

    // Single deposit on terminal 2
    f_acct[2] = 12'hfff; f_pin[2] = 12'hfff; f_dst[2] = 12'h123; f_amt[2] = 12'h11f; f_op[2] = 3'd0;
    pack_fields();
    bus.req = 4'b0100;
    wait_out(2, 10, cyc);
    chk("lat_gnt", 32'(cyc), 32'd1);
    wait_out(0, 10, cyc);
    chk("lat_start", 32'(cyc), 32'd2);
    chk("dep_gnt",      32'(bus.gnt),          32'h4);
    chk("dep_acct",     32'(bus.eng_acct),     32'hfff);
    chk("dep_deposit",  32'(bus.eng_deposit),  32'h11f);
    chk("dep_withdraw", 32'(bus.eng_withdraw), 32'h0);
    chk("dep_transfer", 32'(bus.eng_transfer), 32'h0);
    chk("model_dep",    32'(e_dep),            32'h11f);
    repeat (2) tick();
    bus.eng_done = 1'b1;
    tick();
    bus.eng_done = 1'b0;
    wait_out(1, 10, cyc);
    chk("dep_done_lat", 32'(cyc),           32'd1);
    chk("dep_done",     32'(bus.term_done), 32'h4);
    chk("dep_err",      32'(bus.term_err),  32'h0);
    bus.req = '0;
    tick();

    // Round-robin from a fresh pointer with immediate completion
    do_reset();
    grant_log.delete();
    d0 = done_count;
    bus.req = 4'b1011; bus.eng_done = 1'b1; bus.eng_err = 1'b0;
    for (int s = 0; s < 4; s++) begin
      wait_out(1, 20, cyc);
      chk("rr_session_done", 32'(cyc > 0), 32'd1);
    end
    bus.req = '0; bus.eng_done = 1'b0;
    tick();
    chk("rr_count", 32'(grant_log.size()), 32'd4);
    chk("rr_order0", 32'(grant_log[0]), 32'd0);
    chk("rr_order1", 32'(grant_log[1]), 32'd1);
    chk("rr_order2", 32'(grant_log[2]), 32'd3);
    chk("rr_order3", 32'(grant_log[3]), 32'd0);
    chk("rr_dones",  32'(done_count - d0), 32'd4);

    // Timeout on terminal 1 (withdraw)
    f_amt[1] = 12'h2a5; f_op[1] = 3'd1;
    pack_fields();
    bus.req = 4'b0010;
    wait_out(0, 10, cyc);
    chk("to_gnt",      32'(bus.gnt),          32'h2);
    chk("to_withdraw", 32'(bus.eng_withdraw), 32'h2a5);
    chk("to_deposit",  32'(bus.eng_deposit),  32'h0);
    wait_out(1, T + 10, cyc);
    chk("to_latency", 32'(cyc),           32'(T + 1));
    chk("to_done",    32'(bus.term_done), 32'h2);
    chk("to_err",     32'(bus.term_err),  32'h2);
    bus.req = '0;
    tick();

    // Done coincident with the last timer cycle; op 3 zeroes all amounts
    f_amt[0] = 12'h777; f_op[0] = 3'd3;
    pack_fields();
    bus.req = 4'b0001;
    wait_out(0, 10, cyc);
    chk("op3_deposit",  32'(bus.eng_deposit),  32'h0);
    chk("op3_withdraw", 32'(bus.eng_withdraw), 32'h0);
    chk("op3_transfer", 32'(bus.eng_transfer), 32'h0);
    chk("op3_op",       32'(bus.eng_op),       32'h3);
    chk("model_op3",    32'(e_tr),             32'h0);
    repeat (T - 1) tick();
    bus.eng_done = 1'b1; bus.eng_err = 1'b0;
    tick();
    bus.eng_done = 1'b0;
    wait_out(1, 5, cyc);
    chk("edge_lat",  32'(cyc),           32'd1);
    chk("edge_done", 32'(bus.term_done), 32'h1);
    chk("edge_err",  32'(bus.term_err),  32'h0);
    bus.req = '0;
    tick();

    // Reset while waiting on the engine
    bus.req = 4'b0100;
    wait_out(0, 10, cyc);
    repeat (2) tick();
    d0 = done_count;
    rst = 1'b0;
    tick();
    chk("mid_gnt",  32'(bus.gnt),       32'h0);
    chk("mid_busy", 32'(bus.busy),      32'h0);
    chk("mid_done", 32'(bus.term_done), 32'h0);
    rst = 1'b1;
    bus.req = 4'b1111;
    wait_out(2, 10, cyc);
    chk("mid_regrant", 32'(bus.gnt), 32'h1);
    chk("mid_nodone",  32'(done_count - d0), 32'd0);
    bus.eng_done = 1'b1;
    wait_out(1, 20, cyc);
    bus.eng_done = 1'b0; bus.req = '0;
    tick();

    // Randomized traffic
    d0 = done_count;
    cnt = -1;
    for (int c = 0; c < 3000; c++) begin
      if (!rst) begin
        rst = 1'b1; cnt = -1;
      end else if ($urandom_range(0, 399) == 0) begin
        rst = 1'b0;
      end
      bus.req = bus.req & ~bus.term_done;
      for (int i = 0; i < N; i++) begin
        if (!bus.req[i] && $urandom_range(0, 5) == 0) begin
          rand_term(i);
          bus.req = bus.req | (N'(1) << i);
        end else if ($urandom_range(0, 3) == 0) begin
          rand_term(i);
        end
      end
      if ($urandom_range(0, 63) == 0) bus.req = bus.req & ~(N'(1) << $urandom_range(0, N - 1));
      pack_fields();
      if (bus.eng_start) cnt = $urandom_range(0, T + 2);
      bus.eng_done = (cnt == 0) || (cnt < 0 && $urandom_range(0, 7) == 0);
      bus.eng_err  = 1'($urandom);
      if (cnt >= 0) cnt--;
      tick();
    end
    rst = 1'b1; bus.req = '0; bus.eng_done = 1'b0;
    repeat (T + 10) tick();
    chk("rnd_activity", 32'(done_count - d0 > 50), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
